// File: rtl/scu_timers_pkg.sv
// scu_timers_pkg: register types, write masks and register selects for the SCU timer stage
package scu_timers_pkg;
  typedef logic [9:0] T0C_t;
  typedef logic [8:0] T1S_t;
  typedef struct packed {
    logic md;
    logic enb;
  } T1MD_t;
  localparam logic [31:0] T0C_MASK = 32'h0000_03FF;
  localparam logic [31:0] T1S_MASK = 32'h0000_01FF;
  localparam logic [31:0] T1MD_MASK = 32'h0000_0003;
  localparam T1MD_t T1MD_INIT = '0;
  typedef enum logic [1:0] {
    T0C = 2'd0,
    T1S = 2'd1,
    T1MD = 2'd2
  } TMR_SEL_t;
endpackage

// File: rtl/scu_timers_if.sv
// scu_timers_if: register write bus from the SCU register file into the timer stage
interface scu_timers_if;
  logic        REG_WR;
  logic [1:0]  REG_SEL;
  logic [31:0] REG_DI;
  modport master (output REG_WR, REG_SEL, REG_DI);
  modport slave (input REG_WR, REG_SEL, REG_DI);
endinterface

// File: rtl/scu_tmr_edge.sv
// scu_tmr_edge: CE-qualified registered edge detector (RISE=1 rising, RISE=0 falling)
module scu_tmr_edge #(
  parameter bit RISE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic d,
  output logic ev
);
  logic d_q, d_d;
  always_comb begin
    d_d = ce ? d : d_q;
    ev = RISE ? d & ~d_q : ~d & d_q;
  end
  always_ff @(posedge clk) d_q <= rst ? 1'b0 : d_d;
endmodule

// File: rtl/scu_timers.sv
// scu_timers: SCU Timer 0/1 with T0C/T1S/T1MD registers; SCU_TIMER_STATUS_EN exposes T0_CNT/T1_CNT
module scu_timers
  import scu_timers_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic CE,
  input  logic T1_TICK,
  input  logic HBLANK,
  input  logic VBLANK,
  scu_timers_if.slave bus,
  output logic T0I,
  output logic T1I
`ifdef SCU_TIMER_STATUS_EN
  ,
  output logic [9:0] T0_CNT,
  output logic [8:0] T1_CNT
`endif
);
  T0C_t t0c_q, t0c_d;
  T1S_t t1s_q, t1s_d;
  T1MD_t t1md_q, t1md_d;
  logic [9:0] t0_cnt_q, t0_cnt_d, t0_nxt;
  logic [8:0] t1_cnt_q, t1_cnt_d;
  logic armed_q, armed_d, t0_line_q, t0_line_d, t0i_q, t0i_d, t1i_q, t1i_d;
  logic hb_ev, vo_ev, t0_hit, tk, zero, on;
  scu_tmr_edge #(.RISE(1'b1)) u_hb (.clk(CLK), .rst(RST), .ce(CE), .d(HBLANK), .ev(hb_ev));
  scu_tmr_edge #(.RISE(1'b0)) u_vb (.clk(CLK), .rst(RST), .ce(CE), .d(VBLANK), .ev(vo_ev));
  always_comb begin
    t0c_d = bus.REG_WR && bus.REG_SEL == T0C ? T0C_t'(10'(bus.REG_DI & T0C_MASK)) : t0c_q;
    t1s_d = bus.REG_WR && bus.REG_SEL == T1S ? T1S_t'(9'(bus.REG_DI & T1S_MASK)) : t1s_q;
    t1md_d = bus.REG_WR && bus.REG_SEL == T1MD ? T1MD_t'(2'(bus.REG_DI & T1MD_MASK)) : t1md_q;
    on = t1md_q.enb;
    t0_nxt = vo_ev ? 10'd0 : hb_ev ? t0_cnt_q + 10'd1 : t0_cnt_q;
    t0_hit = (hb_ev | vo_ev) && t0_nxt == t0c_q;
    // a tick coinciding with the HBlank reload is dropped
    tk = T1_TICK && armed_q && !hb_ev;
    zero = t1_cnt_q == 9'd0;
    t0_cnt_d = !on ? 10'd0 : CE ? t0_nxt : t0_cnt_q;
    t0_line_d = !on ? 1'b0 : !CE ? t0_line_q : t0_hit ? 1'b1 : hb_ev ? 1'b0 : t0_line_q;
    t1_cnt_d = !on ? 9'd0 : !CE ? t1_cnt_q : hb_ev ? t1s_q : tk && !zero ? t1_cnt_q - 9'd1 : t1_cnt_q;
    armed_d = !on ? 1'b0 : !CE ? armed_q : hb_ev ? 1'b1 : tk && zero ? 1'b0 : armed_q;
    t0i_d = !on ? 1'b0 : !CE ? t0i_q : t0_hit;
    t1i_d = !on ? 1'b0 : !CE ? t1i_q : tk && zero && (!t1md_q.md || t0_line_q);
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      t0c_q <= '0;
      t1s_q <= '0;
      t1md_q <= T1MD_INIT;
      t0_cnt_q <= '0;
      t1_cnt_q <= '0;
      armed_q <= 1'b0;
      t0_line_q <= 1'b0;
      t0i_q <= 1'b0;
      t1i_q <= 1'b0;
    end else begin
      t0c_q <= t0c_d;
      t1s_q <= t1s_d;
      t1md_q <= t1md_d;
      t0_cnt_q <= t0_cnt_d;
      t1_cnt_q <= t1_cnt_d;
      armed_q <= armed_d;
      t0_line_q <= t0_line_d;
      t0i_q <= t0i_d;
      t1i_q <= t1i_d;
    end
  end
  assign T0I = t0i_q;
  assign T1I = t1i_q;
`ifdef SCU_TIMER_STATUS_EN
  assign T0_CNT = t0_cnt_q;
  assign T1_CNT = t1_cnt_q;
`endif
endmodule

// File: tb/tb_scu_timers.sv
// tb_scu_timers: directed and random stimulus scored against a line/tick-count model of the timers
module tb_scu_timers;
  logic CLK = 1'b0;
  logic RST, CE, T1_TICK, HBLANK, VBLANK, T0I, T1I;
`ifdef SCU_TIMER_STATUS_EN
  logic [9:0] T0_CNT;
  logic [8:0] T1_CNT;
`endif
  scu_timers_if bus ();
  scu_timers dut (
    .CLK(CLK), .RST(RST), .CE(CE), .T1_TICK(T1_TICK), .HBLANK(HBLANK), .VBLANK(VBLANK),
    .bus(bus.slave), .T0I(T0I), .T1I(T1I)
`ifdef SCU_TIMER_STATUS_EN
    , .T0_CNT(T0_CNT), .T1_CNT(T1_CNT)
`endif
  );
  always #5 CLK = ~CLK;

  typedef struct {
    int tag;
    int t0i;
    int t1i;
    int c0;
    int c1;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int cyc = 0, n_chk = 0, n_fail = 0;
  int m_t0c, m_t1s, m_md, m_enb, m_line, m_reload, m_ticks;
  bit m_live, m_lm, m_phb, m_pvb, m_o0, m_o1;
  bit hb_l, vb_l;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Model: Timer 0 is a line number since VBlank-out; Timer 1 fires on tick number T1S+1 of a line
  task automatic model(input bit rst, input bit ce, input bit tick, input bit hb, input bit vb,
                       input bit wr, input bit [1:0] sel, input bit [31:0] di);
    bit hbev, voev, lm_old;
    if (rst) begin
      m_t0c = 0; m_t1s = 0; m_md = 0; m_enb = 0; m_line = 0; m_reload = 0; m_ticks = 0;
      m_live = 0; m_lm = 0; m_phb = 0; m_pvb = 0; m_o0 = 0; m_o1 = 0;
      return;
    end
    hbev = ce && hb && !m_phb;
    voev = ce && !vb && m_pvb;
    if (ce) begin
      m_phb = hb;
      m_pvb = vb;
    end
    if (m_enb == 0) begin
      m_line = 0; m_reload = 0; m_ticks = 0; m_live = 0; m_lm = 0; m_o0 = 0; m_o1 = 0;
    end else if (ce) begin
      lm_old = m_lm;
      m_o0 = 0;
      m_o1 = 0;
      if (hbev || voev) begin
        m_line = voev ? 0 : (m_line + 1) % 1024;
        if (m_line == m_t0c) begin
          m_o0 = 1;
          m_lm = 1;
        end else if (hbev) m_lm = 0;
      end
      if (hbev) begin
        m_reload = m_t1s;
        m_ticks = 0;
        m_live = 1;
      end else if (tick && m_live) begin
        m_ticks++;
        if (m_ticks == m_reload + 1) begin
          m_live = 0;
          m_o1 = (m_md == 0) || lm_old;
        end
      end
    end
    if (wr) begin
      if (sel == 2'd0) m_t0c = int'(di & 32'h3FF);
      else if (sel == 2'd1) m_t1s = int'(di & 32'h1FF);
      else if (sel == 2'd2) begin
        m_enb = int'(di[0]);
        m_md = int'(di[1]);
      end
    end
  endtask

  task automatic drive(input bit ce, input bit tick, input bit hb, input bit vb, input bit wr = 0,
                       input bit [1:0] sel = 0, input bit [31:0] di = 0, input bit rst = 0);
    exp_t e;
    CE = ce; T1_TICK = tick; HBLANK = hb; VBLANK = vb; RST = rst;
    bus.REG_WR = wr; bus.REG_SEL = sel; bus.REG_DI = di;
    hb_l = hb;
    vb_l = vb;
    model(rst, ce, tick, hb, vb, wr, sel, di);
    e.tag = cyc + 1;
    e.t0i = int'(m_o0);
    e.t1i = int'(m_o1);
    e.c0 = m_line;
    e.c1 = m_live ? m_reload - m_ticks : 0;
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1, 0, hb_l, vb_l);
  endtask
  task automatic wreg(input bit [1:0] s, input bit [31:0] d);
    drive(1, 0, hb_l, vb_l, 1, s, d);
  endtask
  task automatic hbp();
    drive(1, 0, 1, vb_l);
    drive(1, 0, 0, vb_l);
  endtask
  task automatic vop();
    drive(1, 0, hb_l, 1);
    drive(1, 0, hb_l, 0);
  endtask
  task automatic ticks(input int n);
    repeat (n) drive(1, 1, hb_l, vb_l);
  endtask

  always @(negedge CLK) begin
    while (exp_q.size() > 0 && exp_q[0].tag <= cyc) begin
      mon_e = exp_q.pop_front();
      chk("T0I", int'(T0I), mon_e.t0i);
      chk("T1I", int'(T1I), mon_e.t1i);
`ifdef SCU_TIMER_STATUS_EN
      chk("T0_CNT", int'(T0_CNT), mon_e.c0);
      chk("T1_CNT", int'(T1_CNT), mon_e.c1);
`endif
    end
  end

  initial begin
    bit ce, tk, wr, rs;
    bit [1:0] s;
    bit [31:0] d;
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    wreg(2, 1); wreg(0, 3); vop(); repeat (3) hbp(); idle(3);
    wreg(0, 0); vop(); idle(2);
    drive(1, 0, 0, 1); drive(1, 0, 1, 0); drive(1, 0, 0, 0); idle(2);
    wreg(1, 2); repeat (2) begin hbp(); ticks(4); end
    wreg(1, 1); hbp(); ticks(2); drive(0, 0, hb_l, vb_l); drive(0, 1, hb_l, vb_l); idle(2);
    wreg(2, 3); wreg(0, 5); wreg(1, 0); vop();
    repeat (7) begin hbp(); ticks(2); end
    wreg(1, 4); hbp(); drive(1, 1, 1, vb_l); ticks(2); wreg(2, 0); ticks(3); hbp();
    wreg(2, 1); wreg(1, 3); hbp(); ticks(3);
    drive(1, 1, hb_l, vb_l, 0, 0, 0, 1); idle(2);
    wreg(2, 1); wreg(0, 32'h7FF); vop(); repeat (1023) hbp(); idle(2); hbp(); idle(2);
    repeat (3000) begin
      ce = ($urandom % 4) != 0;
      tk = ($urandom % 2) != 0;
      if ($urandom % 8 == 0) hb_l = ~hb_l;
      if ($urandom % 24 == 0) vb_l = ~vb_l;
      wr = ($urandom % 30) == 0;
      s = 2'($urandom % 4);
      d = s == 2'd0 ? (($urandom % 4 == 0) ? $urandom : $urandom % 8) :
          s == 2'd1 ? $urandom % 4 :
          s == 2'd2 ? ((($urandom % 2) << 1) | 32'(($urandom % 8) != 0)) : $urandom;
      rs = ($urandom % 600) == 0;
      drive(ce, tk, hb_l, vb_l, wr, s, d, rs);
    end
    idle(3);
    repeat (5) if (exp_q.size() > 0) @(negedge CLK);
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/scu_timers.md
# scu_timers

SCU timer stage: holds the T0C, T1S and T1MD registers and runs Timer 0 (line-compare) and Timer 1 (in-line countdown) from VDP2 blanking signals. It is written by the SCU register file, which applies the package masks. It emits single-CE-cycle T0I/T1I requests that the SCU interrupt status logic latches into IST bits T0I/T1I, subject to IMS masking downstream.

## Interface
Parameters: none.

- CLK  in  1  system clock.
- RST  in  1  reset, synchronous, active-high.
- CE  in  1  clock enable; all timer state advances only on CLK edges with CE=1.
- T1_TICK  in  1  Timer 1 decrement strobe, qualified by CE.
- HBLANK  in  1  VDP2 HBlank level; HBlank-in = rising edge sampled on CE.
- VBLANK  in  1  VDP2 VBlank level; VBlank-out = falling edge sampled on CE.
- REG_WR  in  1  register write strobe, independent of CE.
- REG_SEL  in  2  0=T0C, 1=T1S, 2=T1MD, 3=ignored.
- REG_DI  in  32  write data; masked with T0C_MASK / T1S_MASK / T1MD_MASK.
- T0I  out  1  Timer 0 interrupt request pulse.
- T1I  out  1  Timer 1 interrupt request pulse.
- T0_CNT  out  10  Timer 0 counter (SCU_TIMER_STATUS_EN only).
- T1_CNT  out  9  Timer 1 counter (SCU_TIMER_STATUS_EN only).

## Operation
- Edge detect: hb_d/vb_d registered on CE. hb_ev = HBLANK & ~hb_d. vo_ev = ~VBLANK & vb_d.
- Registers: T0C 10b, T1S 9b, T1MD {MD, ENB}; load on REG_WR per REG_SEL. No readback.
- ENB=0: t0_cnt, t1_cnt, armed, t0_line forced to 0; T0I/T1I held 0. Edge registers keep running.
- Timer 0: vo_ev → t0_cnt=0; else hb_ev → t0_cnt+1, wrapping 3FF→000. vo_ev wins if both occur.
- Timer 0 match: if an event (hb_ev or vo_ev) produces a new t0_cnt equal to T0C → T0I pulse, t0_line=1.
- t0_line: cleared by any hb_ev that does not produce a match.
- Timer 1 reload: hb_ev → t1_cnt=T1S, armed=1.
- Timer 1 tick: T1_TICK with armed and no hb_ev:
  - t1_cnt≠0 → decrement.
  - t1_cnt==0 → armed=0; T1I pulse if MD=0, or if MD=1 and t0_line=1.
- Timer 1 fires at most once per line. hb_ev with a simultaneous tick: reload wins, tick dropped.
- T1S write mid-line: no effect until the next hb_ev.
- T0C write: compared only at subsequent events; no retroactive match.

## Timing
- Reset: T0C=0, T1S=0, T1MD=0, t0_cnt=0, t1_cnt=0, armed=0, t0_line=0, hb_d=0, vb_d=0, T0I=0, T1I=0, T0_CNT=0, T1_CNT=0.
- Event sampled on CE cycle N → counter updated at end of N → T0I/T1I high during CE cycle N+1.
- Pulses are exactly one CE period wide, held across intervening CE=0 clocks.
- Register write is visible to timer logic on the following CLK edge.
- T1 latency: T1S=k fires on the (k+1)-th T1_TICK after hb_ev.
- Reset mid-line: all state cleared in the same cycle; a pending pulse is dropped.

## Configuration
- SCU_TIMER_STATUS_EN defined: T0_CNT/T1_CNT ports exist and mirror the live counters (debug/OSD).
- Not defined: ports absent; counter logic unchanged.

## Structure
- Reuse package types T0C_t, T1S_t, T1MD_t and masks T0C_MASK, T1S_MASK, T1MD_MASK, T1MD_INIT.
- Add to the package: TMR_SEL_t enum (T0C, T1S, T1MD).
- Sub-module scu_tmr_edge: registered rise/fall detector on CE. Instantiated twice (HBLANK, VBLANK).

## Test plan
1. ENB=1, T0C=3: VBlank-out then 3 HBlank-in → T0I pulses once, one CE after the 3rd hb_ev; T0_CNT=3.
2. T0C=0, ENB=1: VBlank-out → T0I the next CE cycle. VBlank-out with simultaneous hb_ev → t0_cnt=0, exactly one T0I.
3. T1S=2, MD=0: hb_ev then 3 ticks → T1I on the CE after the 3rd tick. 4th tick → no pulse. Next line repeats.
4. MD=1, T0C=5, T1S=0: T1I only on line 5 (first tick after its hb_ev); lines 4 and 6 → none.
5. Tick coincident with hb_ev: counter=T1S, tick ignored. ENB cleared mid-count → counters 0, no pulses.
6. RST asserted one cycle before an expected T1I → no pulse; all outputs 0. Write T0C=0x7FF → stored 0x3FF.
